// File: rtl/wb_port_arbiter_pkg.sv
// Shared types for the register-file write-port arbiter.
// Latency: n/a (types and default widths only).
// Backpressure: n/a.
package wb_arb_pkg;

    localparam int WB_DATA_W = 32;
    localparam int WB_ADDR_W = 5;

    typedef struct packed {
        logic [WB_ADDR_W-1:0] rd;
        logic [WB_DATA_W-1:0] data;
    } wb_req_t;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_PIPE,
        GNT_AUX,
        GNT_AUX_FORCED
    } grant_e;

endpackage

// File: rtl/wb_port_arbiter_fifo.sv
// Small synchronous FIFO holding aux write requests until the port is free.
// Latency: push in cycle N is visible at head in N+1; pop takes effect at the edge.
// Backpressure: full blocks push (push while full is dropped); pop while empty is ignored.
module wb_arb_fifo
    import wb_arb_pkg::*;
#(
    parameter int  DEPTH = 2,
    parameter type T     = wb_req_t
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  T     push_dat,
    input  logic pop,
    output logic full,
    output logic empty,
    output T     head
);

    // Extra pointer bit distinguishes full from empty when the indices wrap.
    localparam int PTR_W = $clog2(DEPTH) + 1;

    T                 mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                   (wr_ptr[PTR_W-2:0] == rd_ptr[PTR_W-2:0]);
    assign head  = mem[rd_ptr[PTR_W-2:0]];

    // Pointer update; reset discards all queued entries.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop && !empty) rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    // Storage write; contents need no reset since the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (push && !full) mem[wr_ptr[PTR_W-2:0]] <= push_dat;
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the single register-file write port between pipeline writeback and a buffered aux requester.
// Latency: grant in cycle N -> rf_* in N+1; aux enqueue in N -> earliest write visible in N+2.
// Backpressure: aux_ready = !full; with WB_ARB_STARVE_GUARD_EN, pipe_stall holds WB for one forced aux drain.
module wb_port_arbiter
    import wb_arb_pkg::*;
#(
    parameter int DATA_W       = WB_DATA_W,
    parameter int ADDR_W       = WB_ADDR_W,
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pipe_we,
    input  logic [ADDR_W-1:0] pipe_rd,
    input  logic [DATA_W-1:0] pipe_data,
    output logic              pipe_stall,
    input  logic              aux_valid,
    output logic              aux_ready,
    input  logic [ADDR_W-1:0] aux_rd,
    input  logic [DATA_W-1:0] aux_data,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              aux_pending
);

    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } req_t;

    req_t   aux_req;
    req_t   head;
    logic   fifo_full;
    logic   fifo_empty;
    logic   fifo_push;
    logic   fifo_pop;
    logic   forced;
    grant_e grant;

    assign aux_req     = '{rd: aux_rd, data: aux_data};
    assign fifo_push   = aux_valid && !fifo_full;
    assign fifo_pop    = (grant == GNT_AUX) || (grant == GNT_AUX_FORCED);
    assign aux_ready   = !fifo_full;
    assign aux_pending = !fifo_empty;

    wb_arb_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (req_t)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (fifo_push),
        .push_dat (aux_req),
        .pop      (fifo_pop),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .head     (head)
    );

`ifdef WB_ARB_STARVE_GUARD_EN
    logic [7:0] starve_cnt;

    assign forced     = !fifo_empty && (starve_cnt == 8'(STARVE_LIMIT));
    assign pipe_stall = pipe_we && forced;

    // Count cycles the aux head loses to the pipeline; saturate at the limit.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (fifo_empty || fifo_pop) begin
            starve_cnt <= '0;
        end else if (grant == GNT_PIPE && starve_cnt != 8'(STARVE_LIMIT)) begin
            starve_cnt <= starve_cnt + 8'd1;
        end
    end
`else
    logic unused_starve_limit;

    assign unused_starve_limit = ^8'(STARVE_LIMIT);
    assign forced              = 1'b0;
    assign pipe_stall          = 1'b0;
`endif

    // Grant priority: forced aux drain, then pipeline, then opportunistic aux.
    always_comb begin
        grant = GNT_NONE;
        if (forced) begin
            grant = GNT_AUX_FORCED;
        end else if (pipe_we) begin
            grant = GNT_PIPE;
        end else if (!fifo_empty) begin
            grant = GNT_AUX;
        end
    end

    // Register the granted write; x0 targets are consumed without asserting rf_we.
    always_ff @(posedge clk) begin
        if (reset) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            unique case (grant)
                GNT_PIPE: begin
                    rf_we    <= (pipe_rd != '0);
                    rf_waddr <= pipe_rd;
                    rf_wdata <= pipe_data;
                end
                GNT_AUX, GNT_AUX_FORCED: begin
                    rf_we    <= (head.rd != '0);
                    rf_waddr <= head.rd;
                    rf_wdata <= head.data;
                end
                default: begin
                    rf_we    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;

`ifdef WB_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pipe_we = 1'b0;
    logic [4:0]  pipe_rd = '0;
    logic [31:0] pipe_data = '0;
    logic        pipe_stall;
    logic        aux_valid = 1'b0;
    logic        aux_ready;
    logic [4:0]  aux_rd = '0;
    logic [31:0] aux_data = '0;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        aux_pending;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    wb_port_arbiter #(
        .DATA_W       (32),
        .ADDR_W       (5),
        .FIFO_DEPTH   (2),
        .STARVE_LIMIT (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pipe_we     (pipe_we),
        .pipe_rd     (pipe_rd),
        .pipe_data   (pipe_data),
        .pipe_stall  (pipe_stall),
        .aux_valid   (aux_valid),
        .aux_ready   (aux_ready),
        .aux_rd      (aux_rd),
        .aux_data    (aux_data),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .aux_pending (aux_pending)
    );

    always #5 clk = ~clk;

    // Scoreboard: every register-file write must match the oldest expected write.
    always @(negedge clk) begin
        exp_t e;
        if (rf_we === 1'b1) begin
            n_checks++;
            if (sb.size() == 0) begin
                $display("FAIL sb_unexpected_write: got addr=%0d data=%h, required no write", rf_waddr, rf_wdata);
            end else begin
                e = sb.pop_front();
                if (rf_waddr !== e.a || rf_wdata !== e.d)
                    $display("FAIL sb_write: got addr=%0d data=%h, required addr=%0d data=%h",
                             rf_waddr, rf_wdata, e.a, e.d);
                else
                    n_pass++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({rf_we, aux_ready, aux_pending, pipe_stall} !== 4'b0100)
            $display("FAIL reset_flags: got we/rdy/pend/stall=%b, required 0100",
                     {rf_we, aux_ready, aux_pending, pipe_stall});
        else n_pass++;
        n_checks++;
        if (rf_waddr !== 5'd0 || rf_wdata !== 32'd0)
            $display("FAIL reset_addr_data: got %0d/%h, required 0/00000000", rf_waddr, rf_wdata);
        else n_pass++;
    endtask

    task automatic test_pipe_priority();
        step();
        pipe_we = 1'b1; pipe_rd = 5'd5; pipe_data = 32'hDEADBEEF;
        aux_valid = 1'b1; aux_rd = 5'd7; aux_data = 32'h0000_1234;
        sb.push_back(exp_t'{5'd5, 32'hDEADBEEF});
        sb.push_back(exp_t'{5'd7, 32'h0000_1234});
        @(negedge clk);
        n_checks++;
        if (pipe_stall !== 1'b0) $display("FAIL prio_no_stall: got %b, required 0", pipe_stall);
        else n_pass++;
        step();
        pipe_we = 1'b0; aux_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || aux_pending !== 1'b1)
            $display("FAIL prio_pipe_first: got we=%b addr=%0d pend=%b, required 1/5/1", rf_we, rf_waddr, aux_pending);
        else n_pass++;
        step();
        @(negedge clk);
        n_checks++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || aux_pending !== 1'b0)
            $display("FAIL prio_aux_next: got we=%b addr=%0d pend=%b, required 1/7/0", rf_we, rf_waddr, aux_pending);
        else n_pass++;
        step();
        @(negedge clk);
        n_checks++;
        if (rf_we !== 1'b0) $display("FAIL prio_idle: got we=%b, required 0", rf_we);
        else n_pass++;
    endtask

    task automatic test_x0_drop();
        step();
        pipe_we = 1'b1; pipe_rd = 5'd0; pipe_data = 32'hFFFFFFFF;
        @(negedge clk);
        n_checks++;
        if (pipe_stall !== 1'b0) $display("FAIL x0_stall: got %b, required 0", pipe_stall);
        else n_pass++;
        step();
        pipe_we = 1'b0;
        @(negedge clk);
        n_checks++;
        if (rf_we !== 1'b0) $display("FAIL x0_we: got %b, required 0", rf_we);
        else n_pass++;
    endtask

    task automatic test_fifo_full();
        for (int k = 0; k < 4; k++) begin
            step();
            pipe_we   = 1'b1;
            pipe_rd   = 5'(11 + k);
            pipe_data = 32'hB000_0000 + 32'(k);
            sb.push_back(exp_t'{pipe_rd, pipe_data});
            aux_valid = (k < 3);
            aux_rd    = 5'(20 + k);
            aux_data  = 32'hC000_0020 + 32'(k);
            @(negedge clk);
            n_checks++;
            if (aux_ready !== (k < 2)) $display("FAIL full_ready_k%0d: got %b, required %b", k, aux_ready, (k < 2));
            else n_pass++;
        end
        step();
        pipe_we = 1'b0; aux_valid = 1'b0;
        sb.push_back(exp_t'{5'd20, 32'hC000_0020});
        sb.push_back(exp_t'{5'd21, 32'hC000_0021});
        @(negedge clk);
        n_checks++;
        if (aux_pending !== 1'b1) $display("FAIL full_pending: got %b, required 1", aux_pending);
        else n_pass++;
        repeat (3) step();
        @(negedge clk);
        n_checks++;
        if (aux_pending !== 1'b0 || aux_ready !== 1'b1)
            $display("FAIL full_drained: got pend=%b rdy=%b, required 0/1", aux_pending, aux_ready);
        else n_pass++;
    endtask

    task automatic test_starvation();
        int  idx;
        logic exp_stall;
        idx = 0;
        for (int k = 0; k < 13; k++) begin
            step();
            pipe_we   = 1'b1;
            pipe_rd   = 5'(10 + idx);
            pipe_data = 32'hA000_0000 + 32'(idx);
            aux_valid = (k == 0);
            aux_rd    = 5'd9;
            aux_data  = 32'h0000_9999;
            @(negedge clk);
            exp_stall = GUARD && (k == 9);
            n_checks++;
            if (pipe_stall !== exp_stall) $display("FAIL starve_stall_k%0d: got %b, required %b", k, pipe_stall, exp_stall);
            else n_pass++;
            if (pipe_stall === 1'b1) begin
                sb.push_back(exp_t'{5'd9, 32'h0000_9999});
            end else begin
                sb.push_back(exp_t'{pipe_rd, pipe_data});
                idx++;
            end
        end
        step();
        pipe_we = 1'b0; aux_valid = 1'b0;
        if (!GUARD) sb.push_back(exp_t'{5'd9, 32'h0000_9999});
        repeat (3) step();
        @(negedge clk);
        n_checks++;
        if (aux_pending !== 1'b0) $display("FAIL starve_drained: got %b, required 0", aux_pending);
        else n_pass++;
    endtask

    task automatic test_reset_mid_drain();
        for (int k = 0; k < 2; k++) begin
            step();
            pipe_we   = 1'b1;
            pipe_rd   = 5'(1 + k);
            pipe_data = 32'hD000_0000 + 32'(k);
            sb.push_back(exp_t'{pipe_rd, pipe_data});
            aux_valid = 1'b1;
            aux_rd    = 5'(25 + k);
            aux_data  = 32'hE000_0025 + 32'(k);
        end
        step();
        reset = 1'b1; aux_valid = 1'b0;
        pipe_rd = 5'd3; pipe_data = 32'hD000_0003;
        @(negedge clk);
        n_checks++;
        if (aux_pending !== 1'b1) $display("FAIL rst_queued: got %b, required 1", aux_pending);
        else n_pass++;
        step();
        reset = 1'b0; pipe_we = 1'b0;
        @(negedge clk);
        n_checks++;
        if (aux_pending !== 1'b0 || rf_we !== 1'b0 || aux_ready !== 1'b1)
            $display("FAIL rst_flush: got pend=%b we=%b rdy=%b, required 0/0/1", aux_pending, rf_we, aux_ready);
        else n_pass++;
        repeat (6) step();
    endtask

    initial begin
        test_reset();
        test_pipe_priority();
        test_x0_drop();
        test_fifo_full();
        test_starvation();
        test_reset_mid_drain();
        n_checks++;
        if (sb.size() != 0) $display("FAIL sb_leftover: got %0d pending writes, required 0", sb.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
